frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/fcc_pkg.sv | 27 ++
 rtl/fcc_edge_det.sv | 26 ++
 rtl/frame_capture_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcc_pkg.sv
// Shared types and constants for the frame capture controller.
package fcc_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } fcc_state_t;

    // Default frame geometry (VGA)
    localparam int FCC_H_ACTIVE_DEF = 640;
    localparam int FCC_V_ACTIVE_DEF = 480;

    localparam int FCC_PIX_W = 10;
    localparam int FCC_CNT_W = 20;

    // Width of a geometry counter that must reach n. Kept at least 5 bits
    // so the low five bits can always be sliced for the test pattern.
    function automatic int fcc_cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 5) ? 5 : w;
    endfunction

endpackage

// File: rtl/fcc_edge_det.sv
// Rise/fall detector: registers the previous sample of a synchronous level
// and flags the cycle in which the level changes.
module fcc_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // Keep one cycle of history; cleared by reset so a level that is already
    // high when reset releases shows up as a fresh rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Single-frame capture controller: arms on capture_req, waits for the start
// of a new camera frame, writes up to H_ACTIVE x V_ACTIVE pixels into the
// frame-store FIFO and reports completion and error status.
// Optional build macro: FCC_TEST_PATTERN_EN replaces the camera pixel with a
// {x[4:0], y[4:0]} coordinate pattern at identical timing.
module frame_capture_ctrl
    import fcc_pkg::*;
#(
    parameter int H_ACTIVE = FCC_H_ACTIVE_DEF,
    parameter int V_ACTIVE = FCC_V_ACTIVE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capture_req,
    input  logic                 clr,
    input  logic                 cam_fval,
    input  logic                 cam_lval,
    input  logic [FCC_PIX_W-1:0] cam_data,
    input  logic                 wr_full,
    output logic                 wr_req,
    output logic [FCC_PIX_W-1:0] wr_data,
    output logic                 img_captured,
    output logic                 busy,
    output logic                 overflow,
    output logic                 short_frame,
    output logic [FCC_CNT_W-1:0] pix_count
);

    localparam int XW = fcc_cnt_w(H_ACTIVE);
    localparam int YW = fcc_cnt_w(V_ACTIVE);
    localparam logic [XW-1:0] X_LIM = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_LIM = YW'(V_ACTIVE);

    fcc_state_t           r_state;
    logic [XW-1:0]        r_x_cnt;
    logic [YW-1:0]        r_y_cnt;
    logic                 r_wr_req;
    logic [FCC_PIX_W-1:0] r_wr_data;
    logic                 r_img_captured;
    logic                 r_busy;
    logic                 r_overflow;
    logic                 r_short_frame;
    logic [FCC_CNT_W-1:0] r_pix_count;

    logic                 w_fval_rise;
    logic                 w_fval_fall;
    logic                 w_lval_rise;
    logic                 w_lval_fall;
    logic                 w_in_capture;
    logic [XW-1:0]        w_x_base;
    logic                 w_pix_valid;
    logic                 w_pix_write;
    logic                 w_pix_drop;
    logic [FCC_PIX_W-1:0] w_pix_word;

    fcc_edge_det u_fval_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (cam_fval),
        .o_rise (w_fval_rise),
        .o_fall (w_fval_fall)
    );

    fcc_edge_det u_lval_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (cam_lval),
        .o_rise (w_lval_rise),
        .o_fall (w_lval_fall)
    );

    assign w_in_capture = (r_state == ST_CAPTURE);

    // Every line starts at column 0, even if the previous line's end was
    // not seen while capturing.
    assign w_x_base = w_lval_rise ? '0 : r_x_cnt;

    // A clr in the same cycle already kills the pixel so no write follows
    // the abort.
    assign w_pix_valid = w_in_capture & cam_fval & cam_lval &
                         (w_x_base < X_LIM) & (r_y_cnt < Y_LIM) & ~clr;
    assign w_pix_write = w_pix_valid & ~wr_full;
    assign w_pix_drop  = w_pix_valid & wr_full;

`ifdef FCC_TEST_PATTERN_EN
    assign w_pix_word = {w_x_base[4:0], r_y_cnt[4:0]};
`else
    assign w_pix_word = cam_data;
`endif

    // Control FSM with its status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_img_captured <= 1'b0;
            r_short_frame  <= 1'b0;
        end else if (clr) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_img_captured <= 1'b0;
            r_short_frame  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (capture_req) begin
                        r_state <= ST_ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // Only a fresh frame start; a frame in progress is skipped.
                    if (w_fval_rise) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_fval_fall) begin
                        r_state        <= ST_DONE;
                        r_busy         <= 1'b0;
                        r_img_captured <= 1'b1;
                        if (r_y_cnt < Y_LIM) begin
                            r_short_frame <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel datapath: raster counters, write strobe, pixel count, overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_wr_req    <= 1'b0;
            r_wr_data   <= '0;
            r_pix_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_wr_req <= w_pix_write;
            if (w_pix_write) begin
                r_wr_data <= w_pix_word;
            end

            if (clr) begin
                r_x_cnt    <= '0;
                r_y_cnt    <= '0;
                r_overflow <= 1'b0;
            end else begin
                // pix_count is kept readable until the next capture is armed.
                if (r_state == ST_IDLE && capture_req) begin
                    r_pix_count <= '0;
                    r_x_cnt     <= '0;
                    r_y_cnt     <= '0;
                end
                if (r_state == ST_ARMED && w_fval_rise) begin
                    r_x_cnt <= '0;
                    r_y_cnt <= '0;
                end
                if (w_in_capture) begin
                    if (w_lval_fall) begin
                        r_x_cnt <= '0;
                        if (r_y_cnt < Y_LIM) begin
                            r_y_cnt <= r_y_cnt + YW'(1);
                        end
                    end else if (w_pix_valid) begin
                        // Dropped pixels still advance x to keep geometry.
                        r_x_cnt <= w_x_base + XW'(1);
                    end else if (w_lval_rise) begin
                        r_x_cnt <= '0;
                    end
                    if (w_pix_write) begin
                        r_pix_count <= r_pix_count + 20'd1;
                    end
                    if (w_pix_drop) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign wr_req       = r_wr_req;
    assign wr_data      = r_wr_data;
    assign img_captured = r_img_captured;
    assign busy         = r_busy;
    assign overflow     = r_overflow;
    assign short_frame  = r_short_frame;
    assign pix_count    = r_pix_count;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Testbench for frame_capture_ctrl (H_ACTIVE=4, V_ACTIVE=3). Frames are
// generated line by line; a frame-level model decides from line/column
// indices which pixels must reach the frame store, and a compare process
// checks all outputs every cycle. Works with or without FCC_TEST_PATTERN_EN.
module tb_frame_capture_ctrl;

    localparam int H = 4;
    localparam int V = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       capture_req;
    logic       clr;
    logic       cam_fval;
    logic       cam_lval;
    logic [9:0] cam_data;
    logic       wr_full;
    logic       wr_req;
    logic [9:0] wr_data;
    logic       img_captured;
    logic       busy;
    logic       overflow;
    logic       short_frame;
    logic [19:0] pix_count;

    always #5 clk = ~clk;

    frame_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_req  (capture_req),
        .clr          (clr),
        .cam_fval     (cam_fval),
        .cam_lval     (cam_lval),
        .cam_data     (cam_data),
        .wr_full      (wr_full),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .img_captured (img_captured),
        .busy         (busy),
        .overflow     (overflow),
        .short_frame  (short_frame),
        .pix_count    (pix_count)
    );

    // Frame-level model state
    typedef enum int {M_IDLE, M_ARMED, M_CAPTURE, M_DONE} mmode_t;
    mmode_t m_mode = M_IDLE;
    bit     m_busy, m_img, m_ovf, m_short;
    int     m_pix;
    int     f_nl;
    logic [9:0] sent [0:7][0:7];

    // Expectations for the outputs after the latest clock edge
    bit         e_valid = 1'b0;
    bit         e_wr, e_busy, e_img, e_ovf, e_short, e_rst;
    logic [9:0] e_data;
    int         e_pix;

    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;
    logic [9:0] wq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] exp_word(input int l, input int c);
`ifdef FCC_TEST_PATTERN_EN
        return {5'(c), 5'(l)};
`else
        return sent[l][c];
`endif
    endfunction

    // One clock of stimulus; fs/fe mark the frame start and frame end cycles,
    // l/c are the line and column of the pixel presented when lv is high.
    task automatic step(input bit fv, input bit lv, input bit full, input bit req,
                        input bit c_clr, input bit rst_a, input int l, input int c,
                        input bit fs, input bit fe);
        logic [9:0] d;
        bit         w;
        logic [9:0] ed;
        d  = 10'($urandom);
        w  = 1'b0;
        ed = '0;
        cam_fval = fv; cam_lval = lv; cam_data = d; wr_full = full;
        capture_req = req; clr = c_clr; rst_n = ~rst_a;
        if (lv && l < 8 && c < 8) sent[l][c] = d;
        if (rst_a) begin
            m_mode = M_IDLE; m_busy = 0; m_img = 0; m_ovf = 0; m_short = 0; m_pix = 0;
        end else if (c_clr) begin
            m_mode = M_IDLE; m_busy = 0; m_img = 0; m_ovf = 0; m_short = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (req) begin m_mode = M_ARMED; m_busy = 1; m_pix = 0; end
                M_ARMED: if (fs) m_mode = M_CAPTURE;
                M_CAPTURE: begin
                    if (fe) begin
                        m_mode = M_DONE; m_busy = 0; m_img = 1;
                        m_short = m_short | (f_nl < V);
                    end else if (fv && lv && l < V && c < H) begin
                        if (full) m_ovf = 1;
                        else begin w = 1; m_pix++; ed = exp_word(l, c); end
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        e_wr = w; e_data = ed; e_busy = m_busy; e_img = m_img; e_ovf = m_ovf;
        e_short = m_short; e_pix = m_pix; e_rst = rst_a; e_valid = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_req();
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_clr();
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    // Camera frame of nl lines x ppl pixels. full_l/full_c: forced full pixel;
    // req_l: capture_req on column 0 of that line; abort_l: clr (or reset when
    // abort_rst) on column 1 of that line; rand_full: random FIFO-full pixels.
    task automatic send_frame(input int nl, input int ppl, input int full_l, input int full_c,
                              input int req_l, input int abort_l, input bit abort_rst,
                              input bit rand_full);
        bit ab;
        bit fl;
        f_nl = nl;
        repeat (2 + $urandom_range(0, 2)) idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int l = 0; l < nl; l++) begin
            for (int c = 0; c < ppl; c++) begin
                ab = (l == abort_l && c == 1);
                fl = (l == full_l && c == full_c) || (rand_full && $urandom_range(0, 7) == 0);
                step(1, 1, fl, (l == req_l && c == 0), ab && !abort_rst, ab && abort_rst, l, c, 0, 0);
            end
            step(1, 0, 0, 0, 0, 0, l, ppl, 0, 0);
            step(1, 0, 0, 0, 0, 0, l, ppl, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (e_valid) begin
            chk("wr_req", int'(wr_req), int'(e_wr));
            if (e_wr && wr_req) chk("wr_data", int'(wr_data), int'(e_data));
            if (e_rst) chk("wr_data_rst", int'(wr_data), 0);
            chk("busy", int'(busy), int'(e_busy));
            chk("img_captured", int'(img_captured), int'(e_img));
            chk("overflow", int'(overflow), int'(e_ovf));
            chk("short_frame", int'(short_frame), int'(e_short));
            chk("pix_count", int'(pix_count), e_pix);
            if (wr_req) begin
                n_wr++;
                wq.push_back(wr_data);
            end
        end
    end

    task automatic frame_begin();
        n_wr = 0;
        wq.delete();
    endtask

    initial begin
        logic [9:0] lit;
        int nl;
        int ab;

        // Reset state
        repeat (3) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("rst_pix_count", int'(pix_count), 0);
        chk("rst_busy", int'(busy), 0);
        idle();

        // Clean 3x4 frame
        do_req();
        chk("armed_busy", int'(busy), 1);
        frame_begin();
        send_frame(3, 4, -1, -1, -1, -1, 0, 0);
        chk("f1_writes", n_wr, 12);
        chk("f1_pix_count", int'(pix_count), 12);
        chk("f1_img", int'(img_captured), 1);
        chk("f1_ovf", int'(overflow), 0);
        chk("f1_short", int'(short_frame), 0);
        if (wq.size() == 12) begin
            chk("f1_raster_6", int'(wq[6]), int'(exp_word(1, 2)));
`ifdef FCC_TEST_PATTERN_EN
            lit = 10'b00010_00001;
            chk("pattern_x2_y1", int'(wq[6]), int'(lit));
`endif
        end
        do_req();
        chk("done_ignores_req", int'(img_captured), 1);

        // capture_req mid-frame: that frame is skipped, next one captured
        do_clr();
        chk("clr_img", int'(img_captured), 0);
        frame_begin();
        send_frame(3, 4, -1, -1, 1, -1, 0, 0);
        chk("mid_req_writes", n_wr, 0);
        frame_begin();
        send_frame(3, 4, -1, -1, -1, -1, 0, 0);
        chk("next_frame_writes", n_wr, 12);

        // FIFO full on pixel (0,1)
        do_clr(); do_req();
        frame_begin();
        send_frame(3, 4, 0, 1, -1, -1, 0, 0);
        chk("ovf_writes", n_wr, 11);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_pix_count", int'(pix_count), 11);
        if (wq.size() == 11) begin
            chk("ovf_pos0", int'(wq[0]), int'(exp_word(0, 0)));
            chk("ovf_pos1", int'(wq[1]), int'(exp_word(0, 2)));
            chk("ovf_last", int'(wq[10]), int'(exp_word(2, 3)));
        end

        // Oversized frame is cropped; short frame flagged
        do_clr(); do_req();
        frame_begin();
        send_frame(5, 6, -1, -1, -1, -1, 0, 0);
        chk("crop_writes", n_wr, 12);
        chk("crop_short", int'(short_frame), 0);
        do_clr(); do_req();
        frame_begin();
        send_frame(2, 4, -1, -1, -1, -1, 0, 0);
        chk("short_flag", int'(short_frame), 1);
        chk("short_pix_count", int'(pix_count), 8);

        // clr during line 1 aborts the capture
        do_clr(); do_req();
        frame_begin();
        send_frame(3, 4, -1, -1, -1, 1, 0, 0);
        chk("abort_writes", n_wr, 5);
        chk("abort_busy", int'(busy), 0);
        chk("abort_img", int'(img_captured), 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        chk("clr_beats_req", int'(busy), 0);
        frame_begin();
        send_frame(3, 4, -1, -1, -1, -1, 0, 0);
        chk("not_armed_writes", n_wr, 0);

        // Reset mid-frame, re-arm inside the same frame: needs a fresh frame
        do_req();
        frame_begin();
        send_frame(3, 4, -1, -1, 2, 0, 1, 0);
        chk("rst_abort_writes", n_wr, 1);
        chk("rst_abort_pix", int'(pix_count), 0);
        frame_begin();
        send_frame(3, 4, -1, -1, -1, -1, 0, 0);
        chk("after_rst_writes", n_wr, 12);

        // Randomized frames checked by the model every cycle
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 1) do_clr();
            if ($urandom_range(0, 3) != 0) do_req();
            nl = $urandom_range(1, 5);
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            send_frame(nl, $urandom_range(2, 6), -1, -1,
                       ($urandom_range(0, 4) == 0) ? 0 : -1,
                       ab, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
